// File: rtl/gate_array_pipe.sv
// ============================================================================
// Module   : gate_array_pipe
// Purpose  : Pipelined WIDTH-bit two-operand logic unit with a per-transaction
//            op select and a built-in truth-table sweep engine that runs all
//            32 op/operand combinations through the pipeline and checks each
//            result against an independent golden path.
// Ports    : clk, rst_n        - clock, asynchronous active-low reset
//            in_valid,a,b,op   - external transaction (ignored while busy)
//            out_valid,out     - registered result, STAGES cycles later
//            sweep_start       - pulse to start a self-test sweep
//            sweep_busy        - sweep in RUN/DRAIN/DONE
//            sweep_done        - one-cycle pulse at sweep end
//            sweep_err         - sticky sweep mismatch flag
//            fault_inj         - only with GATE_ARRAY_PIPE_FAULT_INJ_EN:
//                                inverts stage-1 result bit 0
// Options  : `define GATE_ARRAY_PIPE_FAULT_INJ_EN adds the fault_inj port.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module gate_array_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  input  logic             sweep_start,
  output logic             sweep_busy,
  output logic             sweep_done,
  output logic             sweep_err
`ifdef GATE_ARRAY_PIPE_FAULT_INJ_EN
  ,
  input  logic             fault_inj
`endif
);

  localparam int         c_LAST       = STAGES - 1;
  localparam logic [4:0] c_DRAIN_LAST = 5'(STAGES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] vec_q, vec_d;
  logic       err_q, err_d;

  logic             w_run;
  logic             w_busy;
  logic             w_start;
  logic             w_in_valid;
  logic [2:0]       w_op;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_stage1;
  logic [3:0]       w_tt;
  logic             w_gold;
  logic             w_mismatch;

  logic [WIDTH-1:0] data_q [STAGES];
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] tag_q;   // entry originates from the sweep engine
  logic [STAGES-1:0] gold_q;  // sweep operands are all-0/all-1, so golden is one replicated bit

  assign w_run   = (state_q == S_RUN);
  assign w_busy  = (state_q != S_IDLE);
  assign w_start = (state_q == S_IDLE) && sweep_start;

  // While busy the external port is locked out; only RUN injects vectors.
  assign w_in_valid = w_busy ? w_run : in_valid;
  assign w_op       = w_run ? vec_q[4:2]           : op;
  assign w_a        = w_run ? {WIDTH{vec_q[1]}}    : a;
  assign w_b        = w_run ? {WIDTH{vec_q[0]}}    : b;

  always_comb begin
    w_res = '0;
    case (w_op)
      3'd0:    w_res = ~(w_a & w_b);
      3'd1:    w_res = w_a & w_b;
      3'd2:    w_res = w_a | w_b;
      3'd3:    w_res = ~(w_a | w_b);
      3'd4:    w_res = w_a ^ w_b;
      3'd5:    w_res = ~(w_a ^ w_b);
      3'd6:    w_res = ~w_a;
      default: w_res = w_a;
    endcase
    w_stage1 = w_res;
`ifdef GATE_ARRAY_PIPE_FAULT_INJ_EN
    w_stage1[0] = w_res[0] ^ fault_inj;
`endif
  end

  // Golden path: a 4-entry truth table per op indexed by {a,b}, kept
  // deliberately different in form from the datapath operators above.
  always_comb begin
    w_tt = 4'h0;
    case (vec_q[4:2])
      3'd0:    w_tt = 4'h7;
      3'd1:    w_tt = 4'h8;
      3'd2:    w_tt = 4'hE;
      3'd3:    w_tt = 4'h1;
      3'd4:    w_tt = 4'h6;
      3'd5:    w_tt = 4'h9;
      3'd6:    w_tt = 4'h3;
      default: w_tt = 4'hC;
    endcase
    w_gold = w_tt[vec_q[1:0]];
  end

  // Data/golden registers only load on valid entries so bubbles leave the
  // previous contents in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        data_q[k]  <= '0;
        valid_q[k] <= 1'b0;
        tag_q[k]   <= 1'b0;
        gold_q[k]  <= 1'b0;
      end
    end else begin
      valid_q[0] <= w_in_valid;
      tag_q[0]   <= w_run;
      if (w_in_valid) begin
        data_q[0] <= w_stage1;
        gold_q[0] <= w_gold;
      end
      for (int k = 1; k < STAGES; k++) begin
        valid_q[k] <= valid_q[k-1];
        tag_q[k]   <= tag_q[k-1];
        if (valid_q[k-1]) begin
          data_q[k] <= data_q[k-1];
          gold_q[k] <= gold_q[k-1];
        end
      end
    end
  end

  assign w_mismatch = valid_q[c_LAST] && tag_q[c_LAST] &&
                      (data_q[c_LAST] != {WIDTH{gold_q[c_LAST]}});

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (sweep_start) begin
          state_d = S_RUN;
          vec_d   = 5'd0;
        end
      end
      S_RUN: begin
        // vec wraps 31 -> 0 and is reused as the drain counter.
        vec_d = vec_q + 5'd1;
        if (vec_q == 5'd31) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        vec_d = vec_q + 5'd1;
        if (vec_q == c_DRAIN_LAST) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    if (w_start)         err_d = 1'b0;
    else if (w_mismatch) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= 5'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
    end
  end

  assign out        = data_q[c_LAST];
  assign out_valid  = valid_q[c_LAST];
  assign sweep_busy = w_busy;
  assign sweep_done = (state_q == S_DONE);
  assign sweep_err  = err_q;

endmodule

`default_nettype wire
